// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared opcodes, FSM state type and default width for alu_addsub_sched
package alu_sched_pkg;
  localparam int DEFAULT_DW = 32;
  localparam logic [3:0] ADDSUB_OP_ADD = 4'd6;
  localparam logic [3:0] ADDSUB_OP_SUB = 4'd7;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} sched_state_t;
endpackage

// File: rtl/alu_addsub_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of first set i_req bit at or after i_ptr; ports i_req, i_ptr, o_gnt (one-hot), o_idx, o_any
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[(int'(i_ptr) + i) % NREQ]) begin
        o_any = 1'b1;
        o_gnt[(int'(i_ptr) + i) % NREQ] = 1'b1;
        o_idx = IDW'((int'(i_ptr) + i) % NREQ);
      end
    end
  end
endmodule

// File: rtl/alu_addsub_sched.sv
// alu_addsub_sched: round-robin share of one registered add/sub unit; req_* in, as_* to unit, rsp_* out, perf_grant_cnt under ALU_ADDSUB_SCHED_PERF_EN
module alu_addsub_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = DEFAULT_DW,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               soc_clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_dat1,
  input  logic [NREQ*DW-1:0] req_dat2,
  input  logic [NREQ-1:0]    req_sub,
  output logic               as_dat_ready,
  output logic [DW-1:0]      as_dat1,
  output logic [DW-1:0]      as_dat2,
  output logic [2:0]         as_opcode,
  output logic [3:0]         as_decrypted_op,
  input  logic [DW-1:0]      as_out,
  input  logic               as_overflow,
  input  logic               as_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_result,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic [NREQ*16-1:0] perf_grant_cnt
);
  sched_state_t r_state, w_next;
  logic [IDW-1:0]  r_ptr, r_id, w_idx;
  logic [NREQ-1:0] w_gnt;
  logic            w_any, r_sub;
  logic [DW-1:0]   r_dat1, r_dat2;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req(req_valid), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_idx(w_idx), .o_any(w_any)
  );
  always_ff @(posedge soc_clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE    ? (w_any ? ISSUE : IDLE) :
             r_state == ISSUE   ? CAPTURE :
             r_state == CAPTURE ? RESP :
             (rsp_ready ? IDLE : RESP);
    req_ready       = r_state == IDLE ? w_gnt : '0;
    as_dat_ready    = r_state == ISSUE;
    as_decrypted_op = r_state == ISSUE ? (r_sub ? ADDSUB_OP_SUB : ADDSUB_OP_ADD) : 4'd0;
    rsp_valid       = r_state == RESP;
  end
  always_ff @(posedge soc_clk or posedge reset)
    if (reset) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_sub        <= 1'b0;
      r_dat1       <= '0;
      r_dat2       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_id   <= w_idx;
        r_sub  <= req_sub[w_idx];
        r_dat1 <= req_dat1[w_idx*DW +: DW];
        r_dat2 <= req_dat2[w_idx*DW +: DW];
      end
      if (r_state == CAPTURE) begin
        rsp_result   <= as_out;
        rsp_overflow <= as_overflow;
        rsp_zero     <= as_zero;
      end
      if (r_state == RESP && rsp_ready)
        r_ptr <= r_id == IDW'(NREQ - 1) ? '0 : r_id + 1'b1;
    end
  assign as_dat1   = r_dat1;
  assign as_dat2   = r_dat2;
  assign as_opcode = 3'b000;
  assign rsp_id    = r_id;
`ifdef ALU_ADDSUB_SCHED_PERF_EN
  logic [15:0] r_cnt [NREQ];
  always_ff @(posedge soc_clk or posedge reset)
    if (reset) for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    else for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i] && r_cnt[i] != 16'hFFFF) r_cnt[i] <= r_cnt[i] + 16'd1;
  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    assign perf_grant_cnt[g*16 +: 16] = r_cnt[g];
  end
`else
  assign perf_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_addsub_sched.sv
// tb_alu_addsub_sched: directed self-checking bench with a behavioural registered add/sub unit
module tb_alu_addsub_sched;
  logic        soc_clk = 1'b0, reset = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, req_sub = '0;
  logic [63:0] req_dat1 = '0, req_dat2 = '0;
  logic        as_dat_ready, as_overflow, as_zero;
  logic [31:0] as_dat1, as_dat2, as_out, rsp_result;
  logic [2:0]  as_opcode;
  logic [3:0]  as_decrypted_op;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_overflow, rsp_zero;
  logic [0:0]  rsp_id;
  logic [31:0] perf_grant_cnt;
  int checks = 0, errors = 0;
  logic [32:0] unit_sum;
  logic [31:0] held;
  alu_addsub_sched #(.NREQ(2), .DW(32)) dut (
    .soc_clk(soc_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dat1(req_dat1), .req_dat2(req_dat2), .req_sub(req_sub),
    .as_dat_ready(as_dat_ready), .as_dat1(as_dat1), .as_dat2(as_dat2), .as_opcode(as_opcode),
    .as_decrypted_op(as_decrypted_op), .as_out(as_out), .as_overflow(as_overflow), .as_zero(as_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .perf_grant_cnt(perf_grant_cnt)
  );
  always #5 soc_clk = ~soc_clk;
  assign unit_sum = as_decrypted_op == 4'd7 ? {1'b0, as_dat1} - {1'b0, as_dat2} : {1'b0, as_dat1} + {1'b0, as_dat2};
  always_ff @(posedge soc_clk or posedge reset)
    if (reset) begin
      as_out <= '0;
      as_overflow <= 1'b0;
      as_zero <= 1'b0;
    end else if (as_dat_ready) begin
      as_out <= unit_sum[31:0];
      as_overflow <= unit_sum[32];
      as_zero <= unit_sum[31:0] == 32'd0;
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic eo, input logic ez);
    @(negedge soc_clk);
    req_valid[r] = 1'b1;
    req_sub[r] = s;
    req_dat1[r*32 +: 32] = a;
    req_dat2[r*32 +: 32] = b;
    rsp_ready = 1'b1;
    #1 chk("accept_ready", 64'(req_ready), 64'(2'b01 << r));
    @(negedge soc_clk);
    req_valid[r] = 1'b0;
    chk("issue_strobe", 64'(as_dat_ready), 64'd1);
    chk("issue_op", 64'(as_decrypted_op), s ? 64'd7 : 64'd6);
    chk("issue_dat", {as_dat1, as_dat2}, {a, b});
    chk("issue_opcode", 64'(as_opcode), 64'd0);
    @(negedge soc_clk);
    chk("capture_idle", {61'd0, as_dat_ready, rsp_valid, |as_decrypted_op}, 64'd0);
    @(negedge soc_clk);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(r));
    chk("rsp_data", {30'd0, rsp_overflow, rsp_zero, rsp_result}, {30'd0, eo, ez, er});
  endtask
  initial begin
    #2 chk("reset_outs", {rsp_result, 26'd0, rsp_valid, as_dat_ready, req_ready, rsp_zero, rsp_overflow}, 64'd0);
    chk("reset_ops", {as_dat1, 28'd0, as_decrypted_op}, 64'd0);
    chk("reset_perf", 64'(perf_grant_cnt), 64'd0);
    @(negedge soc_clk);
    @(negedge soc_clk);
    reset = 1'b0;
    run_op(0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0);
    run_op(1, 32'd9, 32'd9, 1'b1, 32'd0, 1'b0, 1'b1);
    run_op(1, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
    run_op(0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge soc_clk);
    reset = 1'b1;
    @(negedge soc_clk);
    reset = 1'b0;
    req_dat1 = {32'd10, 32'd10};
    req_dat2 = {32'd3, 32'd3};
    req_sub = 2'b10;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_grant", 64'(req_ready), (k % 2) ? 64'd2 : 64'd1);
      @(negedge soc_clk);
      chk("rr_one_strobe", 64'(as_dat_ready), 64'd1);
      @(negedge soc_clk);
      @(negedge soc_clk);
      chk("rr_rsp", {31'd0, rsp_valid, rsp_id, rsp_result[30:0]}, {31'd0, 1'b1, 1'(k % 2), (k % 2) ? 31'd7 : 31'd13});
      @(negedge soc_clk);
    end
`ifdef ALU_ADDSUB_SCHED_PERF_EN
    chk("perf_counts", 64'(perf_grant_cnt), {32'd0, 16'd3, 16'd3});
`endif
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1 chk("bp_grant0", 64'(req_ready), 64'd1);
    @(negedge soc_clk);
    req_valid = 2'b10;
    @(negedge soc_clk);
    @(negedge soc_clk);
    held = rsp_result;
    chk("bp_first", {31'd0, rsp_valid, held}, {31'd0, 1'b1, 32'd13});
    for (int k = 0; k < 5; k++) begin
      @(negedge soc_clk);
      chk("bp_hold", {29'd0, rsp_valid, as_dat_ready, |req_ready, rsp_result}, {29'd0, 3'b100, held});
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_noready", 64'(req_ready), 64'd0);
    @(negedge soc_clk);
    chk("bp_next_grant", 64'(req_ready), 64'd2);
    @(negedge soc_clk);
    req_valid = 2'b00;
    @(negedge soc_clk);
    @(negedge soc_clk);
    chk("bp_rsp1", {31'd0, rsp_valid, rsp_id, rsp_result[30:0]}, {31'd0, 1'b1, 1'b1, 31'd7});
    @(negedge soc_clk);
    req_valid = 2'b01;
    #1 chk("rst_pre_grant", 64'(req_ready), 64'd1);
    @(negedge soc_clk);
    req_valid = 2'b00;
    @(negedge soc_clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid_outs", {as_dat1, 25'd0, rsp_valid, as_dat_ready, req_ready, |as_decrypted_op, rsp_result[0]}, 64'd0);
    chk("rst_mid_perf", 64'(perf_grant_cnt), 64'd0);
    @(negedge soc_clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge soc_clk);
      chk("rst_no_rsp", {62'd0, rsp_valid, as_dat_ready}, 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_addsub_sched.md
Name: alu_addsub_sched

Overview:
- Round-robin scheduler that shares the single registered add/sub unit between NREQ requesters (e.g. PC-increment and execute).
- Accepts operand requests over valid/ready and issues one operation at a time to the unit: pulses its data-ready and drives the op code (6 = add, 7 = sub).
- Captures the registered result one cycle after issue and returns it with the requester id over a valid/ready response channel.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 32, operand/result width; must match the add/sub unit.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- soc_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_dat1  in  NREQ*DW  packed first operands.
- req_dat2  in  NREQ*DW  packed second operands.
- req_sub  in  NREQ  1 = subtract, 0 = add.
- as_dat_ready  out  1  issue strobe to the add/sub unit.
- as_dat1  out  DW  operand 1 to the unit.
- as_dat2  out  DW  operand 2 to the unit.
- as_opcode  out  3  ALU opcode; always 3'b000.
- as_decrypted_op  out  4  4'd6 add, 4'd7 sub.
- as_out  in  DW  registered result from the unit.
- as_overflow  in  1  carry/borrow bit (bit DW) from the unit.
- as_zero  in  1  zero flag from the unit.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester served.
- rsp_result  out  DW  result.
- rsp_overflow  out  1  captured overflow.
- rsp_zero  out  1  captured zero.
- perf_grant_cnt  out  NREQ*16  per-requester grant counters (optional feature).

Behaviour:
- Reset (async, active-high): state IDLE; rr pointer 0; all outputs 0; as_decrypted_op = 0; holding registers cleared.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid, the round-robin grant picks the first valid index starting at ptr (wrapping at NREQ).
  - req_ready[g] = 1 combinationally that cycle; operands, sub and id are latched; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE: for exactly one cycle, as_dat_ready = 1, as_dat1/as_dat2 = latched operands, as_decrypted_op = sub ? 7 : 6. Go to CAPTURE.
- CAPTURE:
  - as_dat_ready = 0; the unit's output is now valid.
  - Latch as_out, as_overflow and as_zero into the rsp registers, set rsp_valid, go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready, clear rsp_valid, set ptr = (id + 1) mod NREQ, and go to IDLE.
  - The next grant happens no earlier than the following cycle.
- Latency: accept at cycle T, strobe at T+1, rsp_valid at T+3.
  - Minimum initiation interval is 4 cycles with rsp_ready held high.
- Operand outputs hold their last values when not issuing; as_decrypted_op returns to 0 after ISSUE.
- Requesters may drop req_valid before being granted; no request is lost once accepted.
- Reset mid-operation: the in-flight request is discarded and no response is produced. The unit shares reset, so its result clears too.
- Wrap-around: ptr = NREQ-1 followed by a grant returns ptr to 0.
- Simultaneous requests: only one grant per IDLE visit; fairness is strict rotation.
- Arithmetic: no arithmetic is done here; the overflow and zero flags are passed through unchanged from the unit.

Optional Feature:
- ALU_ADDSUB_SCHED_PERF_EN defined:
  - One 16-bit counter per requester increments on each req_valid && req_ready handshake.
  - Counters saturate at 16'hFFFF and clear on reset.
- Not defined: perf_grant_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Package alu_sched_pkg holds:
  - localparams ADDSUB_OP_ADD = 4'd6 and ADDSUB_OP_SUB = 4'd7;
  - typedef enum logic [1:0] sched_state_t {IDLE, ISSUE, CAPTURE, RESP};
  - the default DW.
- One sub-module: rr_arbiter (parameter NREQ). Inputs are the request vector and ptr; outputs are the one-hot grant, grant index and any flag. It is purely combinational.

Test Plan:
- Single add: req0 dat1=5, dat2=7, sub=0 -> one as_dat_ready pulse with op 6; rsp at T+3: id=0, result=12, overflow=0, zero=0.
- Subtract to zero and borrow: req1 9-9 -> result 0, zero=1. Then req1 3-5 -> result 32'hFFFFFFFE, overflow=1.
- Carry: req0 32'hFFFFFFFF + 1 -> result 0, overflow=1, zero=1.
- Contention: req0 and req1 both held valid for 6 grants -> grants alternate 0,1,0,1,0,1 starting from ptr 0; each rsp_id matches its grant.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_* stable, req_ready stays 0, no extra as_dat_ready. On release, the next grant comes one cycle later.
- Async reset asserted during CAPTURE, mid-cycle -> outputs 0 immediately and no rsp_valid after release. With PERF_EN, counters read 0.
